uart_tx_arbiter: RTL

//  Shares the single uart transmitter (din/wr_en/tx_busy) between NREQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-level sharing of one uart transmitter among NREQ byte streams
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        uart_din,
  output logic              uart_wr_en,
  input  logic              uart_tx_busy,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [NREQ-1:0] grant_n, ack_n;
  logic [PW-1:0] ptr, ptr_n, g, g_n, win, cand;
  logic [7:0] din_n, byte_cnt, cnt_n;
  logic wr_n, last_q, last_n, found;
  assign busy = state != IDLE;
  // descending scan so the nearest index after ptr is the one left standing
  always_comb begin
    found = 1'b0;
    win = ptr;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    ack_n = '0;
    wr_n = 1'b0;
    din_n = uart_din;
    ptr_n = ptr;
    g_n = g;
    cnt_n = byte_cnt;
    last_n = last_q;
    case (state)
      IDLE: if (found) begin
        grant_n = '0;
        grant_n[win] = 1'b1;
        g_n = win;
        cnt_n = '0;
        state_n = LOAD;
      end
      LOAD: if (!uart_tx_busy) begin
        wr_n = 1'b1;
        ack_n[g] = 1'b1;
        din_n = req_data[8*g +: 8];
        last_n = req_last[g];
        cnt_n = byte_cnt + 8'd1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: state_n = uart_tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: if (!uart_tx_busy) begin
        if (last_q || byte_cnt == 8'(MAX_BURST) || !req[g]) begin
          ptr_n = g;
          grant_n = '0;
          state_n = IDLE;
        end else state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      req_ack <= '0;
      uart_wr_en <= 1'b0;
      uart_din <= '0;
      ptr <= PW'(NREQ - 1);
      g <= '0;
      byte_cnt <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      req_ack <= ack_n;
      uart_wr_en <= wr_n;
      uart_din <= din_n;
      ptr <= ptr_n;
      g <= g_n;
      byte_cnt <= cnt_n;
      last_q <= last_n;
    end
  end
endmodule
